regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: the ALU result path (A) and the load/memory result path (B). It arbitrates round-robin with a valid/ready handshake and registers the winning write into a one-stage write buffer that drives the register file's write port (regwrite, dest, write_data). The same write buffer is compared against both read addresses to flag, or optionally forward, read-after-write hazards. The block sits between the writeback stage and the two-read-port register file wrapper.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- CNT_W, 16, width of the saturating conflict counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- a_valid / a_ready  in / out  1 / 1  requester A handshake
- a_dest / a_data  in  ADDR_W / DATA_W  requester A write target and data
- b_valid / b_ready  in / out  1 / 1  requester B handshake
- b_dest / b_data  in  ADDR_W / DATA_W  requester B write target and data
- regwrite  out  1  register file write enable
- dest  out  ADDR_W  register file write address
- write_data  out  DATA_W  register file write data
- address1, address2  in  ADDR_W  register file read addresses for the current cycle
- hazard1, hazard2  out  1  read port n would return stale data
- fwd1_valid, fwd2_valid  out  1  forwarded data is valid for read port n
- fwd1_data, fwd2_data  out  DATA_W  forwarded data for read port n
- conflict_cnt  out  CNT_W  number of cycles in which A and B were both valid

## Operation
- **Grant rule (combinational):**
  - Only one valid requester: that requester is granted.
  - Both valid: grant the requester that did not win the last contention.
  - last_grant is updated only on contested cycles. It resets to B, so the first contention goes to A.
- **Handshake:**
  - a_ready = grant_A and b_ready = grant_B. Ready never asserts without the matching valid.
  - A transfer happens on valid & ready.
  - A losing requester must hold valid, dest and data stable until it is granted.
- **Write buffer:** on a transfer, load wb_valid=1, wb_dest and wb_data. With no transfer, wb_valid=0. The buffer drains every cycle.
- **Write port:**
  - regwrite = wb_valid & (wb_dest != 0).
  - dest = wb_dest and write_data = wb_data.
  - A write to $zero is accepted and consumes the slot, but is never written.
- **Hazard detection (combinational):** hit_n = wb_valid & (wb_dest != 0) & (address_n == wb_dest).
- **Conflict counter:** increments in every cycle where a_valid & b_valid, and saturates at all-ones.
- **Reset mid-operation:** a pending buffered write is discarded and not retried. The requester that was holding valid re-competes after reset deasserts.

## Timing
- **Reset values:**
  - wb_valid=0, so regwrite=0; dest=0, write_data=0.
  - last_grant=B, conflict_cnt=0.
  - a_ready and b_ready are 0 while reset is asserted.
- **Latency:** a transfer at edge N produces regwrite high during cycle N+1, and the register file captures it at edge N+2.
- **Throughput:** one write per cycle. When both requesters are held valid, grants alternate A, B, A, B.
- **Hazard window:** a hit is raised in exactly the cycle in which the write buffer holds the matching dest. These outputs are combinational from address_n.

## Configuration
- **REGFILE_BYPASS_EN defined:**
  - On hit_n: fwd_n_valid=1, fwd_n_data=wb_data, hazard_n=0.
  - Otherwise fwd_n_valid=0 and fwd_n_data=0.
- **REGFILE_BYPASS_EN undefined:**
  - hazard_n = hit_n.
  - fwd_n_valid is tied to 0 and fwd_n_data to 0.
  - The bypass mux is not synthesised.
- The port list is identical in both builds.

## Structure
- **Package mips_rf_pkg:**
  - DATA_W, ADDR_W, ZERO_REG=5'd0.
  - typedef wb_req_t {dest, data}.
  - enum grant_e {GRANT_A, GRANT_B}.
- **Sub-module rr_arbiter2:** two request bits in, one-hot grant out, holds last_grant. It uses the same clk and reset.
- The write buffer, hazard compare and conflict counter live in regfile_write_arbiter.

## Test plan
- **Reset:** reset pulse while a_valid=1 → regwrite=0, a_ready=0 during reset; after release, A is granted and regwrite is seen with the A dest/data two edges later.
- **Single requester:** A only, a_dest=5, a_data=32'hDEAD_BEEF → a_ready=1 the same cycle; next cycle regwrite=1, dest=5, write_data=32'hDEADBEEF.
- **Contention:** both valid for 4 cycles (A dest 3, B dest 7), each requester held until granted → grants A, B, A, B; conflict_cnt=4.
- **$zero write:** B writes dest=0, data=32'h1234 → b_ready=1; next cycle regwrite=0 and hazard1=0 for address1=0.
- **Hazard:** A writes r9=32'hCAFE, then address1=9 in the buffered cycle:
  - Without REGFILE_BYPASS_EN: hazard1=1, fwd1_valid=0.
  - With REGFILE_BYPASS_EN: hazard1=0, fwd1_valid=1, fwd1_data=32'hCAFE.
- **Counter saturation:** with CNT_W=4, hold both valid for 20 cycles → conflict_cnt stops at 15.

Source files
------------

// File: rtl/mips_rf_pkg.sv
// Shared widths, write-request record and grant encoding for the register-file
// write arbiter and its round-robin sub-arbiter.
package mips_rf_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    // Writes to $zero consume a slot but never reach the register file.
    function automatic logic is_live_dest(input logic [ADDR_W-1:0] d);
        return d != ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of requester handshakes, register-file write port and read-hazard
// signals; slave is the arbiter side, master the writeback/regfile side.
interface regfile_write_arbiter_if;
    import mips_rf_pkg::*;

    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_dest;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_dest;
    logic [DATA_W-1:0] b_data;

    logic              regwrite;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] write_data;

    logic [ADDR_W-1:0] address1;
    logic [ADDR_W-1:0] address2;
    logic              hazard1;
    logic              hazard2;
    logic              fwd1_valid;
    logic              fwd2_valid;
    logic [DATA_W-1:0] fwd1_data;
    logic [DATA_W-1:0] fwd2_data;

    modport slave (
        input  a_valid, a_dest, a_data, b_valid, b_dest, b_data, address1, address2,
        output a_ready, b_ready, regwrite, dest, write_data,
        output hazard1, hazard2, fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
    );

    modport master (
        output a_valid, a_dest, a_data, b_valid, b_dest, b_data, address1, address2,
        input  a_ready, b_ready, regwrite, dest, write_data,
        input  hazard1, hazard2, fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: one-hot grant (bit0 = A, bit1 = B); the
// last-winner memory only moves on contested cycles and resets to B.
module rr_arbiter2
    import mips_rf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    grant_e r_last_grant;
    grant_e w_last_grant_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= GRANT_B;
        end else begin
            r_last_grant <= w_last_grant_next;
        end
    end

    always_comb begin
        o_grant           = 2'b00;
        w_last_grant_next = r_last_grant;
        case (i_req)
            2'b01: o_grant = 2'b01;
            2'b10: o_grant = 2'b10;
            2'b11: begin
                if (r_last_grant == GRANT_B) begin
                    o_grant           = 2'b01;
                    w_last_grant_next = GRANT_A;
                end else begin
                    o_grant           = 2'b10;
                    w_last_grant_next = GRANT_B;
                end
            end
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback via
// a one-stage write buffer, with RAW hazard flags; REGFILE_BYPASS_EN adds forwarding.
module regfile_write_arbiter
    import mips_rf_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]        conflict_cnt
);

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_xfer_a;
    logic              w_xfer_b;
    wb_req_t           w_win_req;
    logic              r_wb_valid;
    wb_req_t           r_wb;
    logic [CNT_W-1:0]  r_conflict_cnt;
    logic              w_wb_live;

    assign w_req = {bus.b_valid, bus.a_valid};

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .reset   (reset),
        .i_req   (w_req),
        .o_grant (w_grant)
    );

    // Ready is held low while reset is asserted so nothing is accepted into a clearing buffer.
    assign bus.a_ready = w_grant[0] & ~reset;
    assign bus.b_ready = w_grant[1] & ~reset;
    assign w_xfer_a    = bus.a_valid & bus.a_ready;
    assign w_xfer_b    = bus.b_valid & bus.b_ready;

    always_comb begin
        w_win_req = '{dest: bus.a_dest, data: bus.a_data};
        if (w_xfer_b) begin
            w_win_req = '{dest: bus.b_dest, data: bus.b_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb       <= '0;
        end else begin
            r_wb_valid <= w_xfer_a | w_xfer_b;
            if (w_xfer_a | w_xfer_b) begin
                r_wb <= w_win_req;
            end
        end
    end

    assign w_wb_live      = r_wb_valid & is_live_dest(r_wb.dest);
    assign bus.regwrite   = w_wb_live;
    assign bus.dest       = r_wb.dest;
    assign bus.write_data = r_wb.data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if (bus.a_valid && bus.b_valid && (r_conflict_cnt != {CNT_W{1'b1}})) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    assign conflict_cnt = r_conflict_cnt;

    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [1:0]        w_hit;
    logic [1:0]        w_hazard;
    logic [1:0]        w_fwd_valid;
    logic [DATA_W-1:0] w_fwd_data [2];

    assign w_rd_addr[0] = bus.address1;
    assign w_rd_addr[1] = bus.address2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
            assign w_hit[gi] = w_wb_live & (w_rd_addr[gi] == r_wb.dest);
`ifdef REGFILE_BYPASS_EN
            assign w_hazard[gi]    = 1'b0;
            assign w_fwd_valid[gi] = w_hit[gi];
            assign w_fwd_data[gi]  = w_hit[gi] ? r_wb.data : '0;
`else
            assign w_hazard[gi]    = w_hit[gi];
            assign w_fwd_valid[gi] = 1'b0;
            assign w_fwd_data[gi]  = '0;
`endif
        end
    endgenerate

    assign bus.hazard1    = w_hazard[0];
    assign bus.hazard2    = w_hazard[1];
    assign bus.fwd1_valid = w_fwd_valid[0];
    assign bus.fwd2_valid = w_fwd_valid[1];
    assign bus.fwd1_data  = w_fwd_data[0];
    assign bus.fwd2_data  = w_fwd_data[1];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized plus directed bench for regfile_write_arbiter against a
// transaction-level model of grants, the buffered write and hazards.
module tb_regfile_write_arbiter;
    import mips_rf_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] conflict_cnt;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who won the last contention, the buffered write, conflict count.
    bit          m_last_b;
    bit          m_wb_valid;
    logic [4:0]  m_wb_dest;
    logic [31:0] m_wb_data;
    int          m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_last_b   = 1'b1;
        m_wb_valid = 1'b0;
        m_wb_dest  = '0;
        m_wb_data  = '0;
        m_cnt      = 0;
    endtask

    task automatic check_port(input string tag, input logic [4:0] addr, input logic hz,
                              input logic fv, input logic [31:0] fd);
        logic hit;
        hit = m_wb_valid && (m_wb_dest != 0) && (addr == m_wb_dest);
`ifdef REGFILE_BYPASS_EN
        check_eq({tag, "_hazard"}, 64'(hz), 64'(0));
        check_eq({tag, "_fwd_valid"}, 64'(fv), 64'(hit));
        check_eq({tag, "_fwd_data"}, 64'(fd), hit ? 64'(m_wb_data) : 64'(0));
`else
        check_eq({tag, "_hazard"}, 64'(hz), 64'(hit));
        check_eq({tag, "_fwd_valid"}, 64'(fv), 64'(0));
        check_eq({tag, "_fwd_data"}, 64'(fd), 64'(0));
`endif
    endtask

    // One clock: check outputs mid-cycle, advance the model at the edge, return the grants.
    task automatic cycle(output bit ga, output bit gb);
        bit contested;
        @(negedge clk);
        contested = bus.a_valid && bus.b_valid;
        ga = bus.a_valid && (!bus.b_valid || m_last_b);
        gb = bus.b_valid && (!bus.a_valid || !m_last_b);
        check_eq("a_ready", 64'(bus.a_ready), 64'(ga));
        check_eq("b_ready", 64'(bus.b_ready), 64'(gb));
        check_eq("regwrite", 64'(bus.regwrite), 64'(m_wb_valid && (m_wb_dest != 0)));
        if (m_wb_valid) begin
            check_eq("dest", 64'(bus.dest), 64'(m_wb_dest));
            check_eq("write_data", 64'(bus.write_data), 64'(m_wb_data));
        end
        check_eq("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
        check_port("rd1", bus.address1, bus.hazard1, bus.fwd1_valid, bus.fwd1_data);
        check_port("rd2", bus.address2, bus.hazard2, bus.fwd2_valid, bus.fwd2_data);
        if (ga || gb) begin
            $display("t=%0t xfer %s dest=%0d data=%08h cnt=%0d", $time, ga ? "A" : "B",
                     ga ? bus.a_dest : bus.b_dest, ga ? bus.a_data : bus.b_data, conflict_cnt);
        end
        @(posedge clk);
        m_wb_valid = ga || gb;
        if (ga) begin
            m_wb_dest = bus.a_dest;
            m_wb_data = bus.a_data;
        end else if (gb) begin
            m_wb_dest = bus.b_dest;
            m_wb_data = bus.b_data;
        end
        if (contested) begin
            m_last_b = gb;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_clear();
        check_eq("rst_a_ready", 64'(bus.a_ready), 64'(0));
        check_eq("rst_b_ready", 64'(bus.b_ready), 64'(0));
        check_eq("rst_regwrite", 64'(bus.regwrite), 64'(0));
        check_eq("rst_dest", 64'(bus.dest), 64'(0));
        check_eq("rst_write_data", 64'(bus.write_data), 64'(0));
        check_eq("rst_cnt", 64'(conflict_cnt), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold_a_ready", 64'(bus.a_ready), 64'(0));
        check_eq("rst_hold_regwrite", 64'(bus.regwrite), 64'(0));
        reset = 1'b0;
    endtask

    function automatic logic [4:0] pick_dest();
        if ($urandom_range(0, 7) == 0) return 5'd0;
        return 5'($urandom_range(0, 31));
    endfunction

    // A requester that is valid but was not granted must hold its request.
    task automatic rand_drive(input bit ga, input bit gb);
        if (!(bus.a_valid && !ga)) begin
            bus.a_valid = ($urandom_range(0, 3) != 0);
            bus.a_dest  = pick_dest();
            bus.a_data  = $urandom;
        end
        if (!(bus.b_valid && !gb)) begin
            bus.b_valid = ($urandom_range(0, 3) != 0);
            bus.b_dest  = pick_dest();
            bus.b_data  = $urandom;
        end
        bus.address1 = ($urandom_range(0, 1) != 0) ? m_wb_dest : 5'($urandom_range(0, 31));
        bus.address2 = ($urandom_range(0, 2) == 0) ? m_wb_dest : 5'($urandom_range(0, 31));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit       ga;
        bit       gb;
        logic [3:0] order;

        reset        = 1'b0;
        bus.a_valid  = 1'b1;
        bus.a_dest   = 5'd12;
        bus.a_data   = 32'h1111_2222;
        bus.b_valid  = 1'b0;
        bus.b_dest   = '0;
        bus.b_data   = '0;
        bus.address1 = '0;
        bus.address2 = '0;
        model_clear();
        #2;

        // Reset with A already requesting; A wins right after release.
        do_reset();
        cycle(ga, gb);
        bus.a_valid = 1'b0;
        cycle(ga, gb);

        // Single requester.
        bus.a_valid = 1'b1; bus.a_dest = 5'd5; bus.a_data = 32'hDEAD_BEEF;
        cycle(ga, gb);
        bus.a_valid = 1'b0;
        cycle(ga, gb);

        // Contention: both held valid for four cycles.
        bus.a_valid = 1'b1; bus.a_dest = 5'd3; bus.a_data = 32'hAAAA_0003;
        bus.b_valid = 1'b1; bus.b_dest = 5'd7; bus.b_data = 32'hBBBB_0007;
        order = '0;
        for (int i = 0; i < 4; i++) begin
            cycle(ga, gb);
            order = {order[2:0], gb};
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        check_eq("contention_order", 64'(order), 64'(4'b0101));
        cycle(ga, gb);
        check_eq("contention_cnt", 64'(conflict_cnt), 64'(4));

        // Write to $zero: accepted but never written, no hazard on r0.
        bus.b_valid = 1'b1; bus.b_dest = 5'd0; bus.b_data = 32'h1234;
        cycle(ga, gb);
        bus.b_valid = 1'b0; bus.address1 = 5'd0;
        cycle(ga, gb);

        // RAW hazard on r9 in the buffered cycle.
        bus.a_valid = 1'b1; bus.a_dest = 5'd9; bus.a_data = 32'hCAFE;
        cycle(ga, gb);
        bus.a_valid = 1'b0; bus.address1 = 5'd9;
        cycle(ga, gb);

        // Saturation of the conflict counter.
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.a_data = $urandom; bus.b_data = $urandom;
            cycle(ga, gb);
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        cycle(ga, gb);
        check_eq("sat_cnt", 64'(conflict_cnt), 64'(CNT_MAX));

        // Reset while a write is buffered; both requesters keep requesting through it.
        bus.a_valid = 1'b1; bus.a_dest = 5'd20; bus.a_data = 32'h0BAD_F00D;
        bus.b_valid = 1'b1; bus.b_dest = 5'd21; bus.b_data = 32'h0000_5EED;
        cycle(ga, gb);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(ga, gb);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        cycle(ga, gb);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rand_drive(ga, gb);
            cycle(ga, gb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
